// File: rtl/fetch_seq.sv
// fetch_seq: instruction sequencer for the CPU core.
//
// Owns the program counter and the instruction register and drives the shared
// memory port through a req/ack handshake. Each instruction runs
// FETCH -> DECODE -> [DATA] -> EXEC. A single exec_en strobe is issued per
// instruction. Jumps, halt and restart are taken in EXEC and HALT.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   mem_req/we/addr  memory request (addr and we are stable while req=1)
//   mem_rdata/ack    memory read data and completion (ack ignored while req=0)
//   instr            instruction register, presented to the decoder
//   ctrl_fetch/we    decoder: the current instruction is LDB/STB, or is STB
//   data_addr        data-phase address from the register file
//   data_strobe      data phase acked (combinational on mem_ack in DATA)
//   exec_en          one-cycle execute strobe
//   jmp/jmp_addr     pc load, sampled in EXEC
//   halt/run         halt after EXEC, restart from HALT
//   halted, pc       status
//   bus_err          sticky request-timeout flag
//
// Optional build macro FETCH_SEQ_TIMEOUT_EN: abandons a request that has
// waited TIMEOUT_CYCLES cycles without ack, sets bus_err and halts. Without
// the macro the sequencer waits for ack indefinitely and bus_err is 0.
module fetch_seq #(
  parameter int unsigned       ADDR_W         = 16,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int unsigned       TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [7:0]        instr,
  input  logic              ctrl_fetch,
  input  logic              ctrl_we,
  input  logic [ADDR_W-1:0] data_addr,
  output logic              data_strobe,
  output logic              exec_en,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              halt,
  input  logic              run,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic              bus_err
);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_DATA, S_EXEC, S_HALT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        instr_q;

`ifdef FETCH_SEQ_TIMEOUT_EN
  localparam int unsigned    TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  // Compared before incrementing, so the request is dropped on the
  // TIMEOUT_CYCLES-th unacked cycle.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
  logic            bus_err_q;
`endif

  // Moore decode from the state register; only data_strobe looks at mem_ack.
  assign mem_req     = (state == S_FETCH) || (state == S_DATA);
  assign mem_we      = (state == S_DATA) && ctrl_we;
  assign mem_addr    = (state == S_DATA) ? data_addr : pc_q;
  assign data_strobe = (state == S_DATA) && mem_ack;
  assign exec_en     = (state == S_EXEC);
  assign halted      = (state == S_HALT);
  assign instr       = instr_q;
  assign pc          = pc_q;
`ifdef FETCH_SEQ_TIMEOUT_EN
  assign bus_err     = bus_err_q;
`else
  assign bus_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_RST;
      pc_q    <= RESET_PC;
      instr_q <= '0;
`ifdef FETCH_SEQ_TIMEOUT_EN
      to_cnt    <= '0;
      bus_err_q <= 1'b0;
`endif
    end else begin
`ifdef FETCH_SEQ_TIMEOUT_EN
      // Held at zero outside an unacked request, so every FETCH/DATA entry
      // starts from a cleared count.
      to_cnt <= '0;
`endif
      case (state)
        S_RST: state <= S_FETCH;
        S_FETCH: begin
          if (mem_ack) begin
            instr_q <= mem_rdata;
            pc_q    <= pc_q + ADDR_W'(1);
            state   <= S_DECODE;
          end
`ifdef FETCH_SEQ_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            bus_err_q <= 1'b1;
            state     <= S_HALT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        S_DECODE: state <= ctrl_fetch ? S_DATA : S_EXEC;
        S_DATA: begin
          if (mem_ack) begin
            state <= S_EXEC;
          end
`ifdef FETCH_SEQ_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            bus_err_q <= 1'b1;
            state     <= S_HALT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        S_EXEC: begin
          // pc already points past this instruction; a jump replaces that.
          if (jmp) pc_q <= jmp_addr;
          state <= halt ? S_HALT : S_FETCH;
        end
        S_HALT: if (run) state <= S_FETCH;
        default: state <= S_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq. Inputs are driven 1 ns after the rising
// edge and outputs are sampled 1 ns later. The random test predicts each
// instruction's bus phases and the resulting pc from the sequencing rules.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata, instr;
  logic        ctrl_fetch, ctrl_we;
  logic [15:0] data_addr, jmp_addr, pc;
  logic        data_strobe, exec_en, jmp, halt, run, halted, bus_err;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_seq #(.ADDR_W(16), .RESET_PC(16'h0000), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .instr(instr),
    .ctrl_fetch(ctrl_fetch), .ctrl_we(ctrl_we), .data_addr(data_addr),
    .data_strobe(data_strobe), .exec_en(exec_en), .jmp(jmp),
    .jmp_addr(jmp_addr), .halt(halt), .run(run), .halted(halted),
    .pc(pc), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_ack = 1'b0; mem_rdata = 8'h00; ctrl_fetch = 1'b0; ctrl_we = 1'b0;
    data_addr = 16'h0; jmp = 1'b0; jmp_addr = 16'h0; halt = 1'b0; run = 1'b0;
  endtask

  // Leaves the bench in the RST cycle with rst_n released; next step is FETCH.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    mem_ack = 1'b1;
    step(); step(); #1;
    n_chk++;
    if ({mem_req, mem_we, exec_en, data_strobe, halted, bus_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000000",
               {mem_req, mem_we, exec_en, data_strobe, halted, bus_err});
    end
    n_chk++;
    if (pc !== 16'h0000 || instr !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_regs: pc=%h instr=%h want 0000/00", pc, instr);
    end
  endtask

  task automatic test_first_fetch();
    do_reset();
    step(); mem_ack = 1'b1; mem_rdata = 8'h12; #1;            // cycle 1
    n_chk++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL first_req: req=%b we=%b addr=%h want 1/0/0000", mem_req, mem_we, mem_addr);
    end
    step(); mem_ack = 1'b0; #1;                                // cycle 2
    n_chk++;
    if (instr !== 8'h12 || pc !== 16'h0001 || mem_req !== 1'b0 || exec_en !== 1'b0) begin
      n_fail++;
      $display("FAIL first_decode: instr=%h pc=%h req=%b exec=%b want 12/0001/0/0",
               instr, pc, mem_req, exec_en);
    end
    step(); #1;                                                // cycle 3
    n_chk++;
    if (exec_en !== 1'b1) begin
      n_fail++; $display("FAIL first_exec: exec_en=%b want 1", exec_en);
    end
    step(); #1;                                                // cycle 4
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0001 || exec_en !== 1'b0) begin
      n_fail++;
      $display("FAIL second_req: req=%b addr=%h exec=%b want 1/0001/0", mem_req, mem_addr, exec_en);
    end
  endtask

  task automatic test_fetch_wait();
    int held = 0;
    int execs = 0;
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3); mem_rdata = 8'hA5; #1;
      if (mem_req === 1'b1 && mem_addr === 16'h0000) held++;
      step();
    end
    mem_ack = 1'b0; #1;
    n_chk++;
    if (held !== 4 || instr !== 8'hA5) begin
      n_fail++; $display("FAIL wait_hold: held=%0d instr=%h want 4/a5", held, instr);
    end
    for (int i = 0; i < 6; i++) begin
      if (exec_en === 1'b1) execs++;
      step(); #1;
    end
    n_chk++;
    if (execs !== 1) begin
      n_fail++; $display("FAIL wait_exec_once: got %0d want 1", execs);
    end
  endtask

  task automatic test_ldb_stb();
    for (int we = 0; we < 2; we++) begin
      do_reset();
      step(); mem_ack = 1'b1; mem_rdata = 8'($urandom); #1;    // cycle 1 FETCH
      step(); mem_ack = 1'b0; ctrl_fetch = 1'b1; ctrl_we = 1'(we);
      data_addr = 16'h8000; #1;                                // cycle 2 DECODE
      n_chk++;
      if (mem_req !== 1'b0) begin
        n_fail++; $display("FAIL data_decode_req: req=%b want 0 (we=%0d)", mem_req, we);
      end
      step(); #1;                                              // cycle 3 DATA
      n_chk++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h8000 || mem_we !== 1'(we) || data_strobe !== 1'b0) begin
        n_fail++;
        $display("FAIL data_req: req=%b addr=%h we=%b strobe=%b want 1/8000/%0d/0",
                 mem_req, mem_addr, mem_we, data_strobe, we);
      end
      mem_ack = 1'b1; #1;
      n_chk++;
      if (data_strobe !== 1'b1 || exec_en !== 1'b0) begin
        n_fail++; $display("FAIL data_strobe: strobe=%b exec=%b want 1/0", data_strobe, exec_en);
      end
      step(); mem_ack = 1'b0; ctrl_fetch = 1'b0; #1;           // cycle 4 EXEC
      n_chk++;
      if (exec_en !== 1'b1 || data_strobe !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL data_exec: exec=%b strobe=%b req=%b want 1/0/0", exec_en, data_strobe, mem_req);
      end
      step(); #1;                                              // cycle 5 FETCH
      n_chk++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0001 || mem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL data_next_fetch: req=%b addr=%h we=%b want 1/0001/0", mem_req, mem_addr, mem_we);
      end
    end
  endtask

  task automatic test_pc_wrap_jump();
    do_reset();
    step(); mem_ack = 1'b1; #1;
    step(); mem_ack = 1'b0; #1;
    step(); jmp = 1'b1; jmp_addr = 16'hFFFF; #1;               // EXEC
    step(); jmp = 1'b0; #1;                                    // FETCH at FFFF
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 16'hFFFF) begin
      n_fail++; $display("FAIL jump_ffff: req=%b addr=%h want 1/ffff", mem_req, mem_addr);
    end
    mem_ack = 1'b1; #1;
    step(); mem_ack = 1'b0; #1;                                // DECODE
    n_chk++;
    if (pc !== 16'h0000) begin
      n_fail++; $display("FAIL pc_wrap: got %h want 0000", pc);
    end
    step(); jmp = 1'b1; jmp_addr = 16'h0040; #1;               // EXEC
    step(); jmp = 1'b0; #1;
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0040 || pc !== 16'h0040) begin
      n_fail++;
      $display("FAIL jump_0040: req=%b addr=%h pc=%h want 1/0040/0040", mem_req, mem_addr, pc);
    end
  endtask

  // Continues from the FETCH at 16'h0040 left by test_pc_wrap_jump.
  task automatic test_halt_jump();
    int bad = 0;
    mem_ack = 1'b1; #1;
    step(); mem_ack = 1'b0; #1;
    step(); halt = 1'b1; jmp = 1'b1; jmp_addr = 16'h0100; #1;  // EXEC
    step(); halt = 1'b0; jmp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mem_ack = 1'b1; #1;                                      // stray ack must not matter
      if (mem_req !== 1'b0 || halted !== 1'b1 || exec_en !== 1'b0) bad++;
      step();
    end
    mem_ack = 1'b0; #1;
    n_chk++;
    if (bad !== 0 || pc !== 16'h0100) begin
      n_fail++; $display("FAIL halt_idle: bad_cycles=%0d pc=%h want 0/0100", bad, pc);
    end
    run = 1'b1;
    step(); run = 1'b0; #1;
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0100 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_run: req=%b addr=%h halted=%b want 1/0100/0", mem_req, mem_addr, halted);
    end
  endtask

  task automatic test_reset_mid_data();
    do_reset();
    step(); mem_ack = 1'b1; mem_rdata = 8'h77; #1;
    step(); mem_ack = 1'b0; ctrl_fetch = 1'b1; data_addr = 16'h1234; #1;
    step(); #1;
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h1234) begin
      n_fail++; $display("FAIL mid_data_req: req=%b addr=%h want 1/1234", mem_req, mem_addr);
    end
    rst_n = 1'b0;
    step(); ctrl_fetch = 1'b0; #1;
    n_chk++;
    if (mem_req !== 1'b0 || pc !== 16'h0000 || instr !== 8'h00 || exec_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_data_reset: req=%b pc=%h instr=%h exec=%b want 0/0000/00/0",
               mem_req, pc, instr, exec_en);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] pc_m, da, ja;
    logic [7:0]  r;
    logic        isd, we, j;
    int          wf, wd;
    do_reset();
    step();
    pc_m = 16'h0000;
    for (int n = 0; n < 40; n++) begin
      wf = $urandom_range(0, 3);
      r  = 8'($urandom);
      for (int i = 0; i <= wf; i++) begin
        mem_ack = (i == wf); mem_rdata = (i == wf) ? r : 8'($urandom);
        run = 1'($urandom);                                    // ignored outside HALT
        #1;
        n_chk++;
        if (mem_req !== 1'b1 || mem_addr !== pc_m || mem_we !== 1'b0 || exec_en !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_fetch[%0d]: req=%b addr=%h we=%b exec=%b want 1/%h/0/0",
                   n, mem_req, mem_addr, mem_we, exec_en, pc_m);
        end
        step();
      end
      run = 1'b0;
      mem_ack = 1'($urandom);                                  // no request: no effect
      isd = (($urandom % 3) == 0); we = 1'($urandom); da = 16'($urandom);
      ctrl_fetch = isd; ctrl_we = we; data_addr = da;
      #1;
      n_chk++;
      if (mem_req !== 1'b0 || instr !== r || pc !== pc_m + 16'd1) begin
        n_fail++;
        $display("FAIL rnd_decode[%0d]: req=%b instr=%h pc=%h want 0/%h/%h",
                 n, mem_req, instr, pc, r, pc_m + 16'd1);
      end
      step();
      if (isd) begin
        wd = $urandom_range(0, 2);
        for (int i = 0; i <= wd; i++) begin
          mem_ack = (i == wd); #1;
          n_chk++;
          if (mem_req !== 1'b1 || mem_addr !== da || mem_we !== we || data_strobe !== (i == wd)) begin
            n_fail++;
            $display("FAIL rnd_data[%0d]: req=%b addr=%h we=%b strobe=%b want 1/%h/%b/%b",
                     n, mem_req, mem_addr, mem_we, data_strobe, da, we, (i == wd));
          end
          step();
        end
      end
      mem_ack = 1'b0; ctrl_fetch = 1'b0;
      j = (($urandom % 4) == 0); ja = 16'($urandom);
      jmp = j; jmp_addr = ja; #1;
      n_chk++;
      if (exec_en !== 1'b1 || mem_req !== 1'b0 || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_exec[%0d]: exec=%b req=%b halted=%b want 1/0/0", n, exec_en, mem_req, halted);
      end
      pc_m = j ? ja : pc_m + 16'd1;
      step(); jmp = 1'b0;
    end
  endtask

`ifdef FETCH_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int held = 0;
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      if (mem_req === 1'b1) held++;
      step();
    end
    #1;
    n_chk++;
    if (held !== 4 || halted !== 1'b1 || bus_err !== 1'b1 || mem_req !== 1'b0 || pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL timeout: held=%0d halted=%b bus_err=%b req=%b pc=%h want 4/1/1/0/0000",
               held, halted, bus_err, mem_req, pc);
    end
    run = 1'b1;
    step(); run = 1'b0; #1;
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || bus_err !== 1'b1 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_restart: req=%b addr=%h bus_err=%b halted=%b want 1/0000/1/0",
               mem_req, mem_addr, bus_err, halted);
    end
  endtask
`else
  task automatic test_no_timeout();
    int bad = 0;
    do_reset();
    step();
    for (int i = 0; i < 300; i++) begin
      #1;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || bus_err !== 1'b0 || halted !== 1'b0) bad++;
      step();
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL no_timeout_wait: bad_cycles=%0d want 0", bad);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_fetch();
    test_fetch_wait();
    test_ldb_stb();
    test_pc_wrap_jump();
    test_halt_jump();
    test_reset_mid_data();
    test_random();
`ifdef FETCH_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
